// File: rtl/iic_sched_pkg.sv
// Shared types and constants for the IIC EEPROM request scheduler.
package iic_sched_pkg;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StIssue  = 3'd1,
        StWait   = 3'd2,
        StGap    = 3'd3,
        StTwr    = 3'd4,
        StReport = 3'd5
    } sched_state_e;

    localparam logic RW_WRITE = 1'b0;
    localparam logic RW_READ  = 1'b1;

endpackage

// File: rtl/iic_sched_rr2.sv
// Two-input round-robin arbiter: combinational grant, pointer moves only on an accepted grant.
module iic_sched_rr2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       accept,
    output logic [1:0] gnt
);

    // ptr_q = 0: port 0 wins a tie; ptr_q = 1: port 1 wins a tie.
    logic ptr_q, ptr_d;

    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = ptr_q ? 2'b10 : 2'b01;
        end
        ptr_d = ptr_q;
        if (accept && (gnt != 2'b00)) begin
            ptr_d = gnt[0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/iic_eeprom_sched.sv
// Schedules write/read requests onto one IIC EEPROM byte engine with retry, timeout and tWR wait.
module iic_eeprom_sched
    import iic_sched_pkg::*;
#(
    parameter int unsigned ADDR_W      = 13,
    parameter int unsigned TWR_CYC     = 250000,
    parameter int unsigned GAP_CYC     = 5000,
    parameter int unsigned TIMEOUT_CYC = 1000000,
    parameter int unsigned MAX_RETRY   = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [7:0]        wr_data,
    output logic              wr_ack,
    output logic              wr_done,
    output logic              wr_err,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_ack,
    output logic              rd_done,
    output logic              rd_err,
    output logic [7:0]        rd_data,
    output logic              eng_start,
    output logic              eng_rw,
    output logic [ADDR_W-1:0] eng_addr,
    output logic [7:0]        eng_wdata,
    input  logic              eng_done,
    input  logic              eng_nack,
    input  logic [7:0]        eng_rdata,
    output logic              busy
);

    localparam int unsigned CNT_MAX =
        (TWR_CYC > GAP_CYC) ? ((TWR_CYC > TIMEOUT_CYC) ? TWR_CYC : TIMEOUT_CYC)
                            : ((GAP_CYC > TIMEOUT_CYC) ? GAP_CYC : TIMEOUT_CYC);
    localparam int unsigned CNT_W = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;
    localparam int unsigned ATT_W = (MAX_RETRY > 1) ? $clog2(MAX_RETRY + 1) : 1;

    sched_state_e      state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
    logic [ATT_W-1:0]  att_q, att_d;
    logic              rw_q, rw_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        wdata_q, wdata_d;
    logic              err_q, err_d;
    logic [7:0]        rd_data_q, rd_data_d;
    // Blocks grants while reset is held and on the first cycle after release.
    logic              ready_q;
    logic              accept;
    logic [1:0]        gnt;
    logic              fail;

    assign accept = ready_q && (state_q == StIdle);

    iic_sched_rr2 u_rr2 (
        .clk    (clk),
        .rst    (rst),
        .req    ({rd_req, wr_req}),
        .accept (accept),
        .gnt    (gnt)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        att_d     = att_q;
        rw_d      = rw_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        err_d     = err_q;
        rd_data_d = rd_data_q;
        wr_ack    = 1'b0;
        rd_ack    = 1'b0;
        eng_start = 1'b0;
        fail      = 1'b0;
        cnt_inc   = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);

        unique case (state_q)
            StIdle: begin
                if (accept && gnt[0]) begin
                    wr_ack  = 1'b1;
                    rw_d    = RW_WRITE;
                    addr_d  = wr_addr;
                    wdata_d = wr_data;
                end else if (accept && gnt[1]) begin
                    rd_ack = 1'b1;
                    rw_d   = RW_READ;
                    addr_d = rd_addr;
                end
                if (accept && (gnt != 2'b00)) begin
                    att_d   = '0;
                    err_d   = 1'b0;
                    state_d = StIssue;
                end
            end
            StIssue: begin
                eng_start = 1'b1;
                cnt_d     = '0;
                state_d   = StWait;
            end
            StWait: begin
                // A done landing on the timeout cycle takes priority over the timeout.
                if (eng_done) begin
                    if (eng_nack) begin
                        fail = 1'b1;
                    end else if (rw_q == RW_WRITE) begin
                        cnt_d   = '0;
                        state_d = StTwr;
                    end else begin
                        rd_data_d = eng_rdata;
                        err_d     = 1'b0;
                        state_d   = StReport;
                    end
                end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                    fail = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
                if (fail) begin
                    if (att_q < ATT_W'(MAX_RETRY)) begin
                        att_d   = att_q + ATT_W'(1);
                        cnt_d   = '0;
                        state_d = StGap;
                    end else begin
                        err_d   = 1'b1;
                        state_d = StReport;
                    end
                end
            end
            StGap: begin
                if (cnt_q == CNT_W'(GAP_CYC - 1)) begin
                    state_d = StIssue;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            StTwr: begin
                if (cnt_q == CNT_W'(TWR_CYC - 1)) begin
                    err_d   = 1'b0;
                    state_d = StReport;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            StReport: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign wr_done   = (state_q == StReport) && (rw_q == RW_WRITE);
    assign rd_done   = (state_q == StReport) && (rw_q == RW_READ);
    assign wr_err    = wr_done && err_q;
    assign rd_err    = rd_done && err_q;
    assign rd_data   = rd_data_q;
    assign eng_rw    = rw_q;
    assign eng_addr  = addr_q;
    assign eng_wdata = wdata_q;
    assign busy      = (state_q != StIdle);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            att_q     <= '0;
            rw_q      <= RW_WRITE;
            addr_q    <= '0;
            wdata_q   <= '0;
            err_q     <= 1'b0;
            rd_data_q <= '0;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            att_q     <= att_d;
            rw_q      <= rw_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            err_q     <= err_d;
            rd_data_q <= rd_data_d;
            ready_q   <= 1'b1;
        end
    end

endmodule
